// File: rtl/driver_display.sv
// SSD1306 128x64 SPI transmit engine: panel reset, power-on init, then one 1030-byte frame per request.
// Define AUTO_REFRESH_EN to stream frames continuously. In that build start is ignored.
module driver_display #(
  parameter int CLK_DIV      = 4,
  parameter int RESET_CYCLES = 1000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [8191:0] imagem,
  input  logic          start,
  output logic          ready,
  output logic          frame_done,
  output logic          oled_sclk,
  output logic          oled_mosi,
  output logic          oled_cs,
  output logic          oled_dc,
  output logic          oled_res
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RST_LOW  = 3'd0,
    ST_RST_WAIT = 3'd1,
    ST_INIT     = 3'd2,
    ST_IDLE     = 3'd3,
    ST_ADDR     = 3'd4,
    ST_DATA     = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [DIV_W-1:0]  div_r, div_s, div_step_s;
  logic [2:0]        bit_r, bit_s, bit_step_s;
  logic [9:0]        idx_r, idx_s, nidx_s;
  logic [7:0]        shift_r, shift_s, shift_step_s, load_byte_s;
  logic              sclk_r, sclk_s, sclk_step_s;
  logic              mosi_r, mosi_s, mosi_step_s;
  logic              dc_r, dc_s, load_dc_s;
  logic              cs_r, cs_s;
  logic              res_r, res_s;
  logic              ready_r, ready_s;
  logic              done_r, done_s;
  logic              byte_end_s, load_s, engine_s, go_s;

  function automatic logic [7:0] init_byte(input logic [4:0] i);
    logic [7:0] b;
    case (i)
      5'd0:  b = 8'hAE;  5'd1:  b = 8'hD5;  5'd2:  b = 8'h80;  5'd3:  b = 8'hA8;
      5'd4:  b = 8'h3F;  5'd5:  b = 8'hD3;  5'd6:  b = 8'h00;  5'd7:  b = 8'h40;
      5'd8:  b = 8'h8D;  5'd9:  b = 8'h14;  5'd10: b = 8'h20;  5'd11: b = 8'h00;
      5'd12: b = 8'hA1;  5'd13: b = 8'hC8;  5'd14: b = 8'hDA;  5'd15: b = 8'h12;
      5'd16: b = 8'h81;  5'd17: b = 8'hCF;  5'd18: b = 8'hD9;  5'd19: b = 8'hF1;
      5'd20: b = 8'hDB;  5'd21: b = 8'h40;  5'd22: b = 8'hA4;  5'd23: b = 8'hA6;
      5'd24: b = 8'hAF;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Column 0..127, page 0..7 window so the 1024 data bytes fill the panel in page-major order.
  function automatic logic [7:0] addr_byte(input logic [2:0] i);
    logic [7:0] b;
    case (i)
      3'd0: b = 8'h21;  3'd1: b = 8'h00;  3'd2: b = 8'h7F;
      3'd3: b = 8'h22;  3'd4: b = 8'h00;  3'd5: b = 8'h07;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

`ifdef AUTO_REFRESH_EN
  logic unused_start_s;
  assign unused_start_s = start;
  assign go_s = 1'b1;
`else
  assign go_s = start;
`endif

  // Byte engine step: each bit is CLK_DIV cycles low then CLK_DIV cycles high.
  always_comb begin
    div_step_s   = div_r;
    bit_step_s   = bit_r;
    shift_step_s = shift_r;
    sclk_step_s  = sclk_r;
    mosi_step_s  = mosi_r;
    byte_end_s   = 1'b0;
    if (div_r == DIV_LAST) begin
      div_step_s = {DIV_W{1'b0}};
      if (sclk_r) begin
        sclk_step_s = 1'b0;
        if (bit_r == 3'd7) begin
          byte_end_s = 1'b1;
        end else begin
          bit_step_s   = bit_r + 3'd1;
          shift_step_s = {shift_r[6:0], 1'b0};
          mosi_step_s  = shift_r[6];
        end
      end else begin
        sclk_step_s = 1'b1;
      end
    end else begin
      div_step_s = div_r + DIV_W'(1);
    end
  end

  // Sequencer next state plus shift/load selection.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    idx_s       = idx_r;
    nidx_s      = idx_r + 10'd1;
    dc_s        = dc_r;
    load_s      = 1'b0;
    load_byte_s = 8'h00;
    load_dc_s   = 1'b0;
    engine_s    = 1'b0;
    case (state_r)
      ST_RST_LOW: begin
        if (cnt_r == RST_LAST) begin
          state_s = ST_RST_WAIT;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_RST_WAIT: begin
        if (cnt_r == RST_LAST) begin
          state_s     = ST_INIT;
          cnt_s       = {CNT_W{1'b0}};
          idx_s       = 10'd0;
          load_s      = 1'b1;
          load_byte_s = init_byte(5'd0);
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_INIT: begin
        if (!byte_end_s) begin
          engine_s = 1'b1;
        end else if (idx_r == 10'd24) begin
          state_s = ST_IDLE;
        end else begin
          idx_s       = nidx_s;
          load_s      = 1'b1;
          load_byte_s = init_byte(nidx_s[4:0]);
        end
      end
      ST_IDLE: begin
        if (go_s) begin
          state_s     = ST_ADDR;
          idx_s       = 10'd0;
          load_s      = 1'b1;
          load_byte_s = addr_byte(3'd0);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (!byte_end_s) begin
          engine_s = 1'b1;
        end else if (idx_r == 10'd5) begin
          state_s     = ST_DATA;
          idx_s       = 10'd0;
          load_s      = 1'b1;
          load_byte_s = imagem[7:0];
          load_dc_s   = 1'b1;
        end else begin
          idx_s       = nidx_s;
          load_s      = 1'b1;
          load_byte_s = addr_byte(nidx_s[2:0]);
        end
      end
      ST_DATA: begin
        if (!byte_end_s) begin
          engine_s = 1'b1;
        end else if (idx_r == 10'd1023) begin
          state_s = ST_DONE;
        end else begin
          idx_s       = nidx_s;
          load_s      = 1'b1;
          load_byte_s = imagem[{nidx_s, 3'b000} +: 8];
          load_dc_s   = 1'b1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_RST_LOW;
      end
    endcase

    if (load_s) begin
      shift_s = load_byte_s;
      mosi_s  = load_byte_s[7];
      bit_s   = 3'd0;
      div_s   = {DIV_W{1'b0}};
      sclk_s  = 1'b0;
      dc_s    = load_dc_s;
    end else if (engine_s) begin
      shift_s = shift_step_s;
      mosi_s  = mosi_step_s;
      bit_s   = bit_step_s;
      div_s   = div_step_s;
      sclk_s  = sclk_step_s;
    end else begin
      shift_s = shift_r;
      mosi_s  = 1'b0;
      bit_s   = 3'd0;
      div_s   = {DIV_W{1'b0}};
      sclk_s  = 1'b0;
    end

    // Pin-level flags follow the next state so they are registered alongside it.
    cs_s    = !((state_s == ST_INIT) || (state_s == ST_ADDR) || (state_s == ST_DATA));
    res_s   = (state_s != ST_RST_LOW);
    ready_s = (state_s == ST_IDLE);
    done_s  = (state_s == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_RST_LOW;
      cnt_r   <= {CNT_W{1'b0}};
      div_r   <= {DIV_W{1'b0}};
      bit_r   <= 3'd0;
      idx_r   <= 10'd0;
      shift_r <= 8'h00;
      sclk_r  <= 1'b0;
      mosi_r  <= 1'b0;
      dc_r    <= 1'b0;
      cs_r    <= 1'b1;
      res_r   <= 1'b0;
      ready_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      div_r   <= div_s;
      bit_r   <= bit_s;
      idx_r   <= idx_s;
      shift_r <= shift_s;
      sclk_r  <= sclk_s;
      mosi_r  <= mosi_s;
      dc_r    <= dc_s;
      cs_r    <= cs_s;
      res_r   <= res_s;
      ready_r <= ready_s;
      done_r  <= done_s;
    end
  end

  assign ready      = ready_r;
  assign frame_done = done_r;
  assign oled_sclk  = sclk_r;
  assign oled_mosi  = mosi_r;
  assign oled_cs    = cs_r;
  assign oled_dc    = dc_r;
  assign oled_res   = res_r;

endmodule

// File: tb/tb_driver_display.sv
// Directed bench for driver_display (CLK_DIV=2, RESET_CYCLES=8): SPI decoder, protocol monitor,
// init sequence, one full frame, ignored mid-frame start and reset mid-byte.
module tb_driver_display;

  logic          clk = 1'b0;
  logic          reset;
  logic [8191:0] imagem;
  logic          start;
  logic          ready, frame_done;
  logic          oled_sclk, oled_mosi, oled_cs, oled_dc, oled_res;

  int errors = 0;
  int checks = 0;
  int proto_err = 0;

  logic [8:0] rx_q[$];
  logic [7:0] init_exp [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
                               8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
                               8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
  logic [7:0] addr_exp [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

  driver_display #(.CLK_DIV(2), .RESET_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .imagem(imagem), .start(start),
    .ready(ready), .frame_done(frame_done),
    .oled_sclk(oled_sclk), .oled_mosi(oled_mosi), .oled_cs(oled_cs),
    .oled_dc(oled_dc), .oled_res(oled_res)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SPI decoder and protocol monitor, sampled on the falling clock edge.
  initial begin
    logic       sclk_p, mosi_p, dc_p, cs_p;
    logic [7:0] sh;
    int         nb;
    sclk_p = 1'b0; mosi_p = 1'b0; dc_p = 1'b0; cs_p = 1'b1; sh = 8'h00; nb = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        nb = 0;
      end else begin
        if (sclk_p && oled_sclk && (oled_mosi !== mosi_p || oled_dc !== dc_p)) proto_err++;
        if (oled_cs && oled_sclk) proto_err++;
        if (oled_cs !== cs_p && nb != 0) proto_err++;
        if (!oled_cs && oled_sclk && !sclk_p) begin
          sh = {sh[6:0], oled_mosi};
          nb++;
          if (nb == 8) begin
            rx_q.push_back({oled_dc, sh});
            nb = 0;
          end
        end
      end
      sclk_p = oled_sclk; mosi_p = oled_mosi; dc_p = oled_dc; cs_p = oled_cs;
    end
  end

  // Reset, release, then time the panel reset phases and the init byte stream.
  task automatic run_init(input string tag);
    int res_at, cs_at, rdy_at;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    rx_q.delete();
    reset = 1'b0;
    res_at = 0; cs_at = 0; rdy_at = 0;
    for (int c = 1; c <= 2000 && rdy_at == 0; c++) begin
      @(negedge clk);
      if (oled_res && res_at == 0) res_at = c;
      if (!oled_cs && cs_at == 0) cs_at = c;
      if (ready) rdy_at = c;
    end
    check({tag, "_res_rise"}, res_at, 8);
    check({tag, "_cs_fall"}, cs_at, 16);
    check({tag, "_ready_at"}, rdy_at, 16 + 25 * 32);
    check({tag, "_nbytes"}, rx_q.size(), 25);
    for (int i = 0; i < 25; i++)
      check($sformatf("%s_byte%0d", tag, i), rx_q[i], {1'b0, init_exp[i]});
  endtask

  initial begin
    int done_at, done_n, ready_bad, dc1_n;
    reset = 1'b1; start = 1'b0; imagem = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", {oled_cs, oled_sclk, oled_mosi, oled_dc, oled_res, ready, frame_done},
          7'b1000000);

    run_init("init1");

    imagem[0 +: 8]       = 8'hA5;
    imagem[8 +: 8]       = 8'h96;
    imagem[513*8 +: 8]   = 8'h0F;
    imagem[1023*8 +: 8]  = 8'h3C;
    rx_q.delete();
    done_at = 0; done_n = 0; ready_bad = 0;
    // Cycle 1 is the first ADDR cycle; the frame occupies 1030*32 cycles after that edge.
    start = 1'b1;
    for (int c = 1; c <= 32970; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        check("ready_drop", ready, 0);
      end
      if (c == 5000) start = 1'b1;
      if (c == 5001) start = 1'b0;
      if (frame_done) begin
        done_n++;
        if (done_at == 0) done_at = c;
      end
      if (ready && c <= 32961) ready_bad++;
    end
    check("done_at", done_at, 1 + 1030 * 32);
    check("done_pulses", done_n, 1);
    check("ready_outside_idle", ready_bad, 0);
    check("ready_back", ready, 1);
    check("cs_idle", oled_cs, 1);
    check("frame_nbytes", rx_q.size(), 1030);
    for (int i = 0; i < 6; i++)
      check($sformatf("addr_byte%0d", i), rx_q[i], {1'b0, addr_exp[i]});
    check("data0", rx_q[6], 9'h1A5);
    check("data1", rx_q[7], 9'h196);
    check("data2", rx_q[8], 9'h100);
    check("data513", rx_q[6 + 513], 9'h10F);
    check("data1022", rx_q[6 + 1022], 9'h100);
    check("data1023", rx_q[6 + 1023], 9'h13C);
    dc1_n = 0;
    foreach (rx_q[i]) if (rx_q[i][8]) dc1_n++;
    check("data_dc_count", dc1_n, 1024);

    // Second frame, interrupted by reset while SCLK is high inside a data byte.
    start = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    check("mid_cs_low", oled_cs, 0);
    check("mid_dc_data", oled_dc, 1);
    check("mid_sclk_high", oled_sclk, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_outs", {oled_cs, oled_sclk, oled_mosi, oled_dc, oled_res, ready, frame_done},
          7'b1000000);
    run_init("init2");

    check("protocol_errs", proto_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
